mem_cmd_master: RTL

- Upstream driver for the 8x8 command memory. It accepts read/write requests over a valid/ready port and buffers them in a small FIFO.
- Issues one command at a time on the memory command bus (write_en/read_en/op/address/write_data), waits for the memory's ready, and returns one response per command.
- Sits between the test/host traffic source and the memory.

---
 rtl/mem_cmd_master.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_cmd_master.sv
// Request-FIFO-fed master for the 8x8 command memory: one command in flight, one response per command.
// Optional build macro CMD_TIMEOUT_EN aborts a command that never sees ready and flags it via rsp_err.
module mem_cmd_master #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [1:0] req_op,
    input  logic [2:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       write_en,
    output logic       read_en,
    output logic [1:0] op,
    output logic [2:0] address,
    output logic [7:0] write_data,
    input  logic       ready,
    input  logic [7:0] read_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_write,
    output logic [2:0] rsp_addr,
    output logic [7:0] rsp_data,
    output logic       rsp_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic       write;
        logic [1:0] op;
        logic [2:0] addr;
        logic [7:0] wdata;
    } req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    req_t             fifo_mem [FIFO_DEPTH];
    req_t             head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_next;
    logic             push, pop;

    state_t     state, state_next;
    logic       write_en_next, read_en_next;
    logic [1:0] op_next;
    logic [2:0] address_next;
    logic [7:0] write_data_next;
    logic       rsp_valid_next, rsp_write_next;
    logic [2:0] rsp_addr_next;
    logic [7:0] rsp_data_next;

`ifdef CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt, tmo_next;
    logic             rsp_err_next;
`else
    wire unused_timeout = (TIMEOUT_CYCLES != 0);
    assign rsp_err = 1'b0;
`endif

    assign push = req_valid && req_ready;
    assign head = fifo_mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (!push && pop)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {req_write, req_op, req_addr, req_wdata};
    end

    // req_ready follows the post-update count, so a full FIFO reopens one cycle after a pop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            req_ready <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count     <= count_next;
            req_ready <= (count_next != FULL_COUNT);
        end
    end

    always_comb begin
        state_next      = state;
        pop             = 1'b0;
        write_en_next   = write_en;
        read_en_next    = read_en;
        op_next         = op;
        address_next    = address;
        write_data_next = write_data;
        rsp_valid_next  = rsp_valid;
        rsp_write_next  = rsp_write;
        rsp_addr_next   = rsp_addr;
        rsp_data_next   = rsp_data;
`ifdef CMD_TIMEOUT_EN
        tmo_next        = tmo_cnt;
        rsp_err_next    = rsp_err;
`endif
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop             = 1'b1;
                    write_en_next   = head.write;
                    read_en_next    = !head.write;
                    op_next         = head.op;
                    address_next    = head.addr;
                    write_data_next = head.wdata;
`ifdef CMD_TIMEOUT_EN
                    tmo_next        = '0;
`endif
                    state_next      = ISSUE;
                end
            end
            ISSUE: begin
                if (ready) begin
                    write_en_next  = 1'b0;
                    read_en_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_write_next = write_en;
                    rsp_addr_next  = address;
                    rsp_data_next  = write_en ? 8'h00 : read_data;
`ifdef CMD_TIMEOUT_EN
                    rsp_err_next   = 1'b0;
`endif
                    state_next     = RESP;
                end
`ifdef CMD_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) begin
                    write_en_next  = 1'b0;
                    read_en_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_write_next = write_en;
                    rsp_addr_next  = address;
                    rsp_data_next  = 8'h00;
                    rsp_err_next   = 1'b1;
                    state_next     = RESP;
                end else begin
                    tmo_next = tmo_cnt + 1'b1;
                end
`endif
            end
            RESP: begin
                // No pop here: the next command waits for IDLE, one cycle after the handshake.
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            write_en   <= 1'b0;
            read_en    <= 1'b0;
            op         <= '0;
            address    <= '0;
            write_data <= '0;
            rsp_valid  <= 1'b0;
            rsp_write  <= 1'b0;
            rsp_addr   <= '0;
            rsp_data   <= '0;
        end else begin
            state      <= state_next;
            write_en   <= write_en_next;
            read_en    <= read_en_next;
            op         <= op_next;
            address    <= address_next;
            write_data <= write_data_next;
            rsp_valid  <= rsp_valid_next;
            rsp_write  <= rsp_write_next;
            rsp_addr   <= rsp_addr_next;
            rsp_data   <= rsp_data_next;
        end
    end

`ifdef CMD_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
            rsp_err <= 1'b0;
        end else begin
            tmo_cnt <= tmo_next;
            rsp_err <= rsp_err_next;
        end
    end
`endif

endmodule
